// File: rtl/vga_pkg.sv
// Shared 640x480 VGA timing defaults, coordinate width and colour types.
// VGA_SCAN_TEST_PATTERN_EN adds the colour-bar lookup used by the test pattern.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned COORD_W  = 11;
  localparam int unsigned PIPE_LAT = 1;
  localparam bit          SYNC_POL = 1'b0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

`ifdef VGA_SCAN_TEST_PATTERN_EN
  // Eight vertical bars, left to right.
  function automatic rgb12_t bar_color(input logic [2:0] idx);
    rgb12_t c;
    case (idx)
      3'd0:    c = rgb12_t'(12'hFFF);
      3'd1:    c = rgb12_t'(12'hFF0);
      3'd2:    c = rgb12_t'(12'h0FF);
      3'd3:    c = rgb12_t'(12'h0F0);
      3'd4:    c = rgb12_t'(12'hF0F);
      3'd5:    c = rgb12_t'(12'hF00);
      3'd6:    c = rgb12_t'(12'h00F);
      default: c = rgb12_t'(12'h000);
    endcase
    return c;
  endfunction
`endif

endpackage

// File: rtl/vga_delay_line.sv
// N-deep, W-wide shift register with a caller-supplied async reset value.
// N = 0 degenerates to a plain wire.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int unsigned N = 1,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (N == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, rst_val};
      assign q = d;
    end else begin : g_shift
      logic [W-1:0] stage_q [N];
      logic [W-1:0] stage_d [N];

      always_comb begin
        stage_d[0] = d;
        for (int unsigned i = 1; i < N; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < N; i++) begin
            stage_q[i] <= rst_val;
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      assign q = stage_q[N-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_timing.sv
// Pixel-clock VGA scan generator: issues x/y to the colour lookup and drives aligned RGB/HS/VS pins.
// Optional VGA_SCAN_TEST_PATTERN_EN adds a test_mode input selecting an eight-bar colour pattern.
module vga_scan_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter int unsigned COORD_W  = vga_pkg::COORD_W,
  parameter int unsigned PIPE_LAT = vga_pkg::PIPE_LAT,
  parameter bit          SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic               clk,
  input  logic               rst,
`ifdef VGA_SCAN_TEST_PATTERN_EN
  input  logic               test_mode,
`endif
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               active,
  output logic               frame_start,
  input  logic [11:0]        color_in,
  output logic [3:0]         R,
  output logic [3:0]         G,
  output logic [3:0]         B,
  output logic               HS,
  output logic               VS
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned ALIGN_W  = 3;

  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;

  // Raster counters: v advances only on the h wrap, both wrap together at frame end.
  always_comb begin
    h_cnt_d = h_cnt_q + COORD_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == COORD_W'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == COORD_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + COORD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  logic active_c;
  logic hs_raw;
  logic vs_raw;

  assign active_c    = (h_cnt_q < COORD_W'(H_ACTIVE)) && (v_cnt_q < COORD_W'(V_ACTIVE));
  assign active      = active_c;
  assign x           = active_c ? h_cnt_q : '0;
  assign y           = active_c ? v_cnt_q : '0;
  assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign hs_raw      = ((h_cnt_q >= COORD_W'(HS_START)) && (h_cnt_q < COORD_W'(HS_END)))
                       ? SYNC_POL : ~SYNC_POL;
  assign vs_raw      = ((v_cnt_q >= COORD_W'(VS_START)) && (v_cnt_q < COORD_W'(VS_END)))
                       ? SYNC_POL : ~SYNC_POL;

  // Delay the control signals by the lookup latency so they meet color_in.
  logic [ALIGN_W-1:0] align_q;
  logic               act_dly;
  logic               hs_dly;
  logic               vs_dly;

  vga_delay_line #(
    .N (PIPE_LAT),
    .W (ALIGN_W)
  ) u_ctrl_dly (
    .clk     (clk),
    .rst_n   (rst),
    .rst_val ({1'b0, ~SYNC_POL, ~SYNC_POL}),
    .d       ({active_c, hs_raw, vs_raw}),
    .q       (align_q)
  );

  assign {act_dly, hs_dly, vs_dly} = align_q;

`ifdef VGA_SCAN_TEST_PATTERN_EN
  logic [COORD_W-1:0] x_dly;
  logic [2:0]         bar_idx;

  vga_delay_line #(
    .N (PIPE_LAT),
    .W (COORD_W)
  ) u_x_dly (
    .clk     (clk),
    .rst_n   (rst),
    .rst_val ('0),
    .d       (x),
    .q       (x_dly)
  );

  assign bar_idx = 3'(x_dly / COORD_W'(H_ACTIVE / 8));
`endif

  rgb12_t rgb_q, rgb_d;
  logic   hs_q, hs_d;
  logic   vs_q, vs_d;

  // Pin register: colour only inside the aligned visible window.
  always_comb begin
    rgb_d = '0;
    hs_d  = hs_dly;
    vs_d  = vs_dly;
    if (act_dly) begin
`ifdef VGA_SCAN_TEST_PATTERN_EN
      rgb_d = test_mode ? bar_color(bar_idx) : rgb12_t'(color_in);
`else
      rgb_d = rgb12_t'(color_in);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= '0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign R  = rgb_q.r;
  assign G  = rgb_q.g;
  assign B  = rgb_q.b;
  assign HS = hs_q;
  assign VS = vs_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: three instances (default, zero-latency, small-raster/inverted-sync)
// checked every cycle against an arithmetic raster model with a history of driven colours.
module tb_vga_scan_timing;
  import vga_pkg::*;

  localparam int unsigned CW = COORD_W;
  localparam int NI = 3;
  localparam int HIST = 1024;

  typedef struct {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    int lat; int pol;
  } tim_t;

  logic clk = 1'b0;
  logic rst;
  logic test_mode;
  logic [CW-1:0] x_o [NI];
  logic [CW-1:0] y_o [NI];
  logic act_o [NI];
  logic fs_o [NI];
  logic hs_o [NI];
  logic vs_o [NI];
  logic [3:0] r_o [NI];
  logic [3:0] g_o [NI];
  logic [3:0] b_o [NI];
  logic [11:0] col_in [NI];

  int checks;
  int errors;
  int n;
  int mode;
  bit tm;
  bit meas;
  logic [11:0] col_hist [NI][HIST];
  bit tm_hist [HIST];
  int hs_fall, hs_rise, vs_on, vs_off, fs_cnt;
  logic prev_hs0, prev_vs2;

  always #5 clk = ~clk;

  vga_scan_timing #(.PIPE_LAT(1)) u_def (
    .clk(clk), .rst(rst),
`ifdef VGA_SCAN_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .x(x_o[0]), .y(y_o[0]), .active(act_o[0]), .frame_start(fs_o[0]),
    .color_in(col_in[0]), .R(r_o[0]), .G(g_o[0]), .B(b_o[0]), .HS(hs_o[0]), .VS(vs_o[0])
  );

  vga_scan_timing #(.PIPE_LAT(0)) u_lat0 (
    .clk(clk), .rst(rst),
`ifdef VGA_SCAN_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .x(x_o[1]), .y(y_o[1]), .active(act_o[1]), .frame_start(fs_o[1]),
    .color_in(col_in[1]), .R(r_o[1]), .G(g_o[1]), .B(b_o[1]), .HS(hs_o[1]), .VS(vs_o[1])
  );

  vga_scan_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .PIPE_LAT(2), .SYNC_POL(1'b1)
  ) u_small (
    .clk(clk), .rst(rst),
`ifdef VGA_SCAN_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .x(x_o[2]), .y(y_o[2]), .active(act_o[2]), .frame_start(fs_o[2]),
    .color_in(col_in[2]), .R(r_o[2]), .G(g_o[2]), .B(b_o[2]), .HS(hs_o[2]), .VS(vs_o[2])
  );

  function automatic tim_t tim(input int i);
    tim_t t;
    if (i == 2) t = '{16, 2, 3, 3, 6, 2, 2, 2, 2, 1};
    else        t = '{640, 16, 96, 48, 480, 10, 2, 33, (i == 0) ? 1 : 0, 0};
    return t;
  endfunction

  // Raster position after s pixel clocks from (0,0).
  function automatic void hv(input int i, input int s, output int h, output int v);
    tim_t t = tim(i);
    int ht = t.ha + t.hf + t.hs + t.hb;
    int vt = t.va + t.vf + t.vs + t.vb;
    h = s % ht;
    v = (s / ht) % vt;
  endfunction

  function automatic logic [11:0] bar_rgb(input int ha, input int h);
    logic [11:0] c;
    case (h / (ha / 8))
      0: c = 12'hFFF;
      1: c = 12'hFF0;
      2: c = 12'h0FF;
      3: c = 12'h0F0;
      4: c = 12'hF0F;
      5: c = 12'hF00;
      6: c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s inst%0d n=%0d: observed %0h expected %0h", tag, i, n, got, exp);
    end
  endtask

  task automatic chk_reset();
    for (int i = 0; i < NI; i++) begin
      tim_t t = tim(i);
      logic idle = (t.pol == 0);
      chk("rst_rgb", i, {r_o[i], g_o[i], b_o[i]}, 0);
      chk("rst_hs", i, hs_o[i], idle);
      chk("rst_vs", i, vs_o[i], idle);
      chk("rst_x", i, x_o[i], 0);
      chk("rst_y", i, y_o[i], 0);
      chk("rst_active", i, act_o[i], 1);
      chk("rst_fstart", i, fs_o[i], 1);
    end
  endtask

  // Compare every output of every instance with the raster model at cycle n.
  task automatic check_cycle();
    for (int i = 0; i < NI; i++) begin
      tim_t t = tim(i);
      int h, v, hk, vk, k;
      bit a, ak;
      logic pol_l;
      logic [11:0] e_rgb;
      logic e_hs, e_vs;
      pol_l = (t.pol != 0);
      hv(i, n, h, v);
      a = (h < t.ha) && (v < t.va);
      chk("x", i, x_o[i], a ? h : 0);
      chk("y", i, y_o[i], a ? v : 0);
      chk("active", i, act_o[i], a);
      chk("fstart", i, fs_o[i], (h == 0) && (v == 0));
      k = n - t.lat - 1;
      e_rgb = '0;
      e_hs = !pol_l;
      e_vs = !pol_l;
      if (k >= 0) begin
        hv(i, k, hk, vk);
        ak = (hk < t.ha) && (vk < t.va);
        if (hk >= t.ha + t.hf && hk < t.ha + t.hf + t.hs) e_hs = pol_l;
        if (vk >= t.va + t.vf && vk < t.va + t.vf + t.vs) e_vs = pol_l;
        if (ak) e_rgb = tm_hist[(n - 1) % HIST] ? bar_rgb(t.ha, hk) : col_hist[i][(n - 1) % HIST];
      end
      chk("R", i, r_o[i], e_rgb[11:8]);
      chk("G", i, g_o[i], e_rgb[7:4]);
      chk("B", i, b_o[i], e_rgb[3:0]);
      chk("HS", i, hs_o[i], e_hs);
      chk("VS", i, vs_o[i], e_vs);
    end
  endtask

  // Colour source: ramp behaves as a lookup of the coordinate issued lat cycles ago.
  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      tim_t t = tim(i);
      int s, h, v;
      logic [11:0] c;
      s = n - t.lat;
      h = 0;
      v = 0;
      if (s >= 0) hv(i, s, h, v);
      case (mode)
        0: c = {4'(h), 4'(v), 4'h5};
        1: c = 12'hABC;
        default: c = 12'($urandom);
      endcase
      col_in[i] = c;
      col_hist[i][n % HIST] = c;
    end
    test_mode = tm;
    tm_hist[n % HIST] = tm;
  endtask

  task automatic measure();
    if (meas) begin
      if (prev_hs0 && !hs_o[0] && hs_fall < 0) hs_fall = n;
      if (!prev_hs0 && hs_o[0] && hs_fall >= 0 && hs_rise < 0) hs_rise = n;
      if (!prev_vs2 && vs_o[2] && vs_on < 0) vs_on = n;
      if (prev_vs2 && !vs_o[2] && vs_on >= 0 && vs_off < 0) vs_off = n;
      if (fs_o[2]) fs_cnt++;
    end
    prev_hs0 = hs_o[0];
    prev_vs2 = vs_o[2];
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
    check_cycle();
    measure();
    drive();
  endtask

  task automatic run(input int cycles);
    repeat (cycles) step();
  endtask

  task automatic release_reset();
    rst = 1'b1;
    n = 0;
    check_cycle();
    drive();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n = 0;
    mode = 0;
    tm = 1'b0;
    meas = 1'b0;
    hs_fall = -1; hs_rise = -1; vs_on = -1; vs_off = -1; fs_cnt = 0;
    prev_hs0 = 1'b1;
    prev_vs2 = 1'b0;
    rst = 1'b0;
    test_mode = 1'b0;
    for (int i = 0; i < NI; i++) col_in[i] = '0;

    repeat (3) begin
      @(negedge clk);
      chk_reset();
    end

    meas = 1'b1;
    release_reset();
    run(1605);
    chk("px32_R", 0, r_o[0], 3);
    chk("px32_G", 0, g_o[0], 2);
    chk("px32_B", 0, b_o[0], 5);
    run(400);
    meas = 1'b0;
    chk("hs_fall_at", 0, hs_fall, 658);
    chk("hs_low_len", 0, hs_rise - hs_fall, 96);
    chk("vs_on_at", 2, vs_on, 3 + 8 * 24);
    chk("vs_len", 2, vs_off - vs_on, 2 * 24);
    chk("frame_pulses", 2, fs_cnt, n / (24 * 12));

    mode = 1;
    run(1000);
    mode = 2;
    run(1000);
`ifdef VGA_SCAN_TEST_PATTERN_EN
    tm = 1'b1;
    run(1000);
    tm = 1'b0;
`endif

    while ((n % 800) != 300) step();
    rst = 1'b0;
    #1;
    chk_reset();
    repeat (2) begin
      @(negedge clk);
      chk_reset();
    end
    release_reset();
    mode = 0;
    run(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
